// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, field positions and control bundle shared by the decode stage
package decode_pkg;
  localparam int INSN_W = 32;
  localparam int OP_W = 5;
  localparam int REG_W = 5;
  localparam int OP_LSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_LSB = 17;
  localparam int RT_LSB = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;
  localparam int IMM_W = 17;
  localparam int TARGET_W = 27;
  localparam logic [OP_W-1:0] OP_R = 5'd0;
  localparam logic [OP_W-1:0] OP_J = 5'd1;
  localparam logic [OP_W-1:0] OP_BNE = 5'd2;
  localparam logic [OP_W-1:0] OP_JAL = 5'd3;
  localparam logic [OP_W-1:0] OP_JR = 5'd4;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
  localparam logic [OP_W-1:0] OP_BLT = 5'd6;
  localparam logic [OP_W-1:0] OP_SW = 5'd7;
  localparam logic [OP_W-1:0] OP_LW = 5'd8;
  localparam logic [OP_W-1:0] OP_SETX = 5'd21;
  localparam logic [OP_W-1:0] OP_BEX = 5'd22;
  typedef struct packed {
    logic regen;
    logic mem_re;
    logic mem_we;
    logic br_ne;
    logic br_lt;
    logic bex;
    logic jump;
    logic jr;
    logic exen;
    logic illegal;
  } ctrl_t;
endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: opcode to control enables, write destination and source-register usage
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int LINK_REG = 31,
  parameter int STATUS_REG = 30
) (
  input  logic [INSN_W-1:RT_LSB] insn,
  output ctrl_t                  ctrl,
  output logic [REG_W-1:0]       wreg,
  output logic [REG_W-1:0]       src_a,
  output logic [REG_W-1:0]       src_b,
  output logic                   use_a,
  output logic                   use_b
);
  logic [OP_W-1:0] op;
  logic [REG_W-1:0] rd, rs, rt;
  logic wr;
  assign op = insn[OP_LSB+:OP_W];
  assign rd = insn[RD_LSB+:REG_W];
  assign rs = insn[RS_LSB+:REG_W];
  assign rt = insn[RT_LSB+:REG_W];
  assign wreg = op == OP_JAL ? REG_W'(LINK_REG) : op == OP_SETX ? REG_W'(STATUS_REG) : rd;
  always_comb begin
    ctrl = '0;
    wr = 1'b0;
    use_a = 1'b0;
    use_b = 1'b0;
    src_a = rs;
    src_b = rt;
    case (op)
      OP_R: begin wr = 1'b1; use_a = 1'b1; use_b = 1'b1; end
      OP_J: ctrl.jump = 1'b1;
      OP_BNE: begin ctrl.br_ne = 1'b1; src_a = rd; src_b = rs; use_a = 1'b1; use_b = 1'b1; end
      OP_JAL: begin ctrl.jump = 1'b1; wr = 1'b1; end
      OP_JR: begin ctrl.jr = 1'b1; src_a = rd; use_a = 1'b1; end
      OP_ADDI: begin wr = 1'b1; use_a = 1'b1; end
      OP_BLT: begin ctrl.br_lt = 1'b1; src_a = rd; src_b = rs; use_a = 1'b1; use_b = 1'b1; end
      OP_SW: begin ctrl.mem_we = 1'b1; src_a = rd; src_b = rs; use_a = 1'b1; use_b = 1'b1; end
      OP_LW: begin ctrl.mem_re = 1'b1; wr = 1'b1; use_a = 1'b1; end
      OP_SETX: begin ctrl.exen = 1'b1; wr = 1'b1; end
      OP_BEX: begin ctrl.bex = 1'b1; ctrl.exen = 1'b1; src_a = REG_W'(STATUS_REG); use_a = 1'b1; end
      default: ctrl.illegal = 1'b1;
    endcase
    ctrl.regen = wr && wreg != '0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered F/D to D/X decode with valid/ready handshake, flush and load-use interlock
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W = 12,
  parameter int DATA_W = 32,
  parameter int LINK_REG = 31,
  parameter int STATUS_REG = 30,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSN_W-1:0]   in_insn,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [REG_W-1:0]    out_rs,
  output logic [REG_W-1:0]    out_rt,
  output logic [REG_W-1:0]    out_wreg,
  output logic [REG_W-1:0]    out_shamt,
  output logic [REG_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]   out_imm,
  output logic [TARGET_W-1:0] out_target,
  output logic                out_regen,
  output logic                out_mem_re,
  output logic                out_mem_we,
  output logic                out_br_ne,
  output logic                out_br_lt,
  output logic                out_bex,
  output logic                out_jump,
  output logic                out_jr,
  output logic                out_exen,
  output logic                out_illegal,
  output logic                hazard_stall
);
  localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);
  ctrl_t ctrl, dx;
  logic [REG_W-1:0] wreg, src_a, src_b, load_rd;
  logic use_a, use_b, hit_a, hit_b, hazard, advance, accept, unused;
  logic [2:0] bub_cnt;
  decode_ctrl #(.LINK_REG(LINK_REG), .STATUS_REG(STATUS_REG)) u_ctrl (
    .insn(in_insn[INSN_W-1:RT_LSB]),
    .ctrl(ctrl),
    .wreg(wreg),
    .src_a(src_a),
    .src_b(src_b),
    .use_a(use_a),
    .use_b(use_b)
  );
  assign unused = ^in_insn[ALUOP_LSB-1:0];
  // A source collides with the lw sitting in D/X, or with one that left D/X fewer than LOAD_BUBBLES slots ago
  assign hit_a = use_a && src_a != '0 &&
                 ((out_valid && dx.mem_re && src_a == out_wreg) || (bub_cnt != '0 && src_a == load_rd));
  assign hit_b = use_b && src_b != '0 &&
                 ((out_valid && dx.mem_re && src_b == out_wreg) || (bub_cnt != '0 && src_b == load_rd));
  assign hazard = hit_a || hit_b;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign accept = in_valid && in_ready;
  assign hazard_stall = in_valid && advance && hazard && !flush;
  assign {out_regen, out_mem_re, out_mem_we, out_br_ne, out_br_lt,
          out_bex, out_jump, out_jr, out_exen, out_illegal} = dx;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_rs <= '0;
      out_rt <= '0;
      out_wreg <= '0;
      out_shamt <= '0;
      out_aluop <= '0;
      out_imm <= '0;
      out_target <= '0;
      dx <= '0;
      load_rd <= '0;
      bub_cnt <= '0;
    end else begin
      if (flush) out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        out_pc <= in_pc;
        out_rs <= in_insn[RS_LSB+:REG_W];
        out_rt <= in_insn[RT_LSB+:REG_W];
        out_wreg <= wreg;
        out_shamt <= in_insn[SHAMT_LSB+:REG_W];
        out_aluop <= in_insn[ALUOP_LSB+:REG_W];
        out_imm <= {{(DATA_W-IMM_W){in_insn[IMM_W-1]}}, in_insn[IMM_W-1:0]};
        out_target <= in_insn[TARGET_W-1:0];
        dx <= ctrl;
      end else if (advance) out_valid <= 1'b0;
      if (out_valid && out_ready && dx.mem_re) begin
        load_rd <= out_wreg;
        bub_cnt <= BUB_INIT;
      end else if (out_ready && bub_cnt != '0) bub_cnt <= bub_cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two lanes (LOAD_BUBBLES=1 and 3) checked every cycle against a spec-level model
module tb_decode_stage;
  typedef struct packed {
    logic [11:0] pc;
    logic [4:0] rs, rt, wreg, shamt, aluop;
    logic [31:0] imm;
    logic [26:0] target;
    logic regen, mem_re, mem_we, br_ne, br_lt, bex, jump, jr, exen, illegal;
  } rec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], iv[2], ordy[2], fl[2], irdy[2], ov[2], hst[2];
  logic [31:0] insn[2];
  logic [11:0] pc[2];
  rec_t dout[2];
  for (genvar k = 0; k < 2; k++) begin : g
    logic [11:0] o_pc;
    logic [4:0] o_rs, o_rt, o_wreg, o_shamt, o_aluop;
    logic [31:0] o_imm;
    logic [26:0] o_target;
    logic regen, mem_re, mem_we, br_ne, br_lt, bex, jump, jr, exen, illegal;
    decode_stage #(.PC_W(12), .DATA_W(32), .LINK_REG(31), .STATUS_REG(30), .LOAD_BUBBLES(k == 0 ? 1 : 3)) dut (
      .clock(clk), .reset(rst[k]), .flush(fl[k]), .in_valid(iv[k]), .in_ready(irdy[k]),
      .in_insn(insn[k]), .in_pc(pc[k]), .out_valid(ov[k]), .out_ready(ordy[k]),
      .out_pc(o_pc), .out_rs(o_rs), .out_rt(o_rt), .out_wreg(o_wreg), .out_shamt(o_shamt),
      .out_aluop(o_aluop), .out_imm(o_imm), .out_target(o_target), .out_regen(regen),
      .out_mem_re(mem_re), .out_mem_we(mem_we), .out_br_ne(br_ne), .out_br_lt(br_lt),
      .out_bex(bex), .out_jump(jump), .out_jr(jr), .out_exen(exen), .out_illegal(illegal),
      .hazard_stall(hst[k])
    );
    assign dout[k] = {o_pc, o_rs, o_rt, o_wreg, o_shamt, o_aluop, o_imm, o_target,
                      regen, mem_re, mem_we, br_ne, br_lt, bex, jump, jr, exen, illegal};
  end
  int checks = 0, errors = 0, cyc = 0, mon = 0, hcnt = 0;
  int fq[$];
  logic mv[2], known[2];
  rec_t mrec[2];
  int since[2];
  logic [4:0] lrd[2];
  function automatic int lb(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic rec_t dec(input logic [31:0] i, input logic [11:0] p);
    rec_t r;
    logic [4:0] op;
    logic w;
    op = i[31:27];
    w = 1'b0;
    r = '0;
    r.pc = p;
    r.rs = i[21:17];
    r.rt = i[16:12];
    r.shamt = i[11:7];
    r.aluop = i[6:2];
    r.imm = {{15{i[16]}}, i[16:0]};
    r.target = i[26:0];
    r.wreg = op == 5'd3 ? 5'd31 : op == 5'd21 ? 5'd30 : i[26:22];
    case (op)
      5'd0, 5'd5: w = 1'b1;
      5'd1: r.jump = 1'b1;
      5'd2: r.br_ne = 1'b1;
      5'd3: begin r.jump = 1'b1; w = 1'b1; end
      5'd4: r.jr = 1'b1;
      5'd6: r.br_lt = 1'b1;
      5'd7: r.mem_we = 1'b1;
      5'd8: begin r.mem_re = 1'b1; w = 1'b1; end
      5'd21: begin r.exen = 1'b1; w = 1'b1; end
      5'd22: begin r.bex = 1'b1; r.exen = 1'b1; end
      default: r.illegal = 1'b1;
    endcase
    r.regen = w && r.wreg != 5'd0;
    return r;
  endfunction
  function automatic logic uses(input logic [31:0] i, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = i[31:27];
    rd = i[26:22];
    rs = i[21:17];
    rt = i[16:12];
    if (r == 5'd0) return 1'b0;
    case (op)
      5'd0: return r == rs || r == rt;
      5'd5, 5'd8: return r == rs;
      5'd2, 5'd6, 5'd7: return r == rd || r == rs;
      5'd4: return r == rd;
      5'd22: return r == 5'd30;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic adv, hz, er;
      adv = !mv[k] || ordy[k];
      hz = (mv[k] && mrec[k].mem_re && uses(insn[k], mrec[k].wreg)) ||
           (since[k] < lb(k) - 1 && uses(insn[k], lrd[k]));
      er = adv && !hz && !fl[k];
      chk($sformatf("out_valid lane%0d cyc%0d", k, cyc), ov[k], mv[k]);
      chk($sformatf("in_ready lane%0d cyc%0d", k, cyc), irdy[k], er);
      chk($sformatf("hazard_stall lane%0d cyc%0d", k, cyc), hst[k], iv[k] && adv && hz && !fl[k]);
      if (known[k]) chk($sformatf("dx lane%0d cyc%0d", k, cyc), dout[k], mrec[k]);
      if (k == mon && ov[k] && ordy[k]) fq.push_back(cyc);
      if (k == mon && hst[k]) hcnt++;
      if (rst[k]) begin
        mv[k] = 1'b0; known[k] = 1'b1; mrec[k] = '0; since[k] = 7; lrd[k] = '0;
      end else begin
        if (mv[k] && ordy[k] && mrec[k].mem_re) begin
          since[k] = 0;
          lrd[k] = mrec[k].wreg;
        end else if (ordy[k] && since[k] < 7) since[k]++;
        if (fl[k]) begin mv[k] = 1'b0; known[k] = 1'b0; end
        else if (iv[k] && er) begin mv[k] = 1'b1; known[k] = 1'b1; mrec[k] = dec(insn[k], pc[k]); end
        else if (adv) begin mv[k] = 1'b0; known[k] = 1'b0; end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int k, input logic [31:0] w);
    iv[k] = 1'b1;
    insn[k] = w;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (irdy[k]) break;
      if (n == 29) begin
        checks++;
        errors++;
        $display("FAIL send timeout lane%0d insn %h", k, w);
      end
    end
    tick;
    iv[k] = 1'b0;
    pc[k] = pc[k] + 12'd1;
  endtask
  function automatic logic [31:0] rt3(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h0};
  endfunction
  function automatic logic [31:0] it(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  task automatic begin_mon(input int k);
    mon = k;
    fq.delete();
    hcnt = 0;
  endtask
  task automatic gap_chk(input string name, input int gap, input int stalls);
    chk({name, " fires"}, fq.size(), 2);
    if (fq.size() >= 2) chk({name, " gap"}, fq[1] - fq[0] - 1, gap);
    chk({name, " stalls"}, hcnt, stalls);
  endtask
  logic [11:0] pc_hold;
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; insn[k] = '0; pc[k] = 12'h100;
      mv[k] = 1'b0; known[k] = 1'b1; mrec[k] = '0; since[k] = 7; lrd[k] = '0;
    end
    repeat (2) tick;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick;
    chk("reset out_valid", ov[0], 1'b0);
    chk("reset outputs", dout[0], '0);
    // load-use with one bubble
    begin_mon(0);
    send(0, it(5'd8, 5'd3, 5'd1, 17'd0));
    send(0, rt3(5'd0, 5'd4, 5'd3, 5'd5));
    repeat (3) tick;
    gap_chk("lb1 lw-add", 1, 1);
    // load-use with three bubbles, then an independent consumer
    begin_mon(1);
    send(1, it(5'd8, 5'd3, 5'd1, 17'd0));
    send(1, rt3(5'd0, 5'd4, 5'd3, 5'd5));
    repeat (3) tick;
    gap_chk("lb3 lw-add", 3, 3);
    begin_mon(1);
    send(1, it(5'd8, 5'd3, 5'd1, 17'd0));
    send(1, rt3(5'd0, 5'd6, 5'd7, 5'd8));
    repeat (3) tick;
    gap_chk("lb3 lw-indep", 0, 0);
    mon = 2;
    // write-destination and immediate cases
    send(0, it(5'd5, 5'd0, 5'd1, 17'd5));
    chk("addi r0 regen", dout[0].regen, 1'b0);
    send(0, {5'd3, 27'h40});
    chk("jal wreg", dout[0].wreg, 5'd31);
    chk("jal regen", dout[0].regen, 1'b1);
    chk("jal target", dout[0].target, 27'h40);
    send(0, {5'd21, 27'd7});
    chk("setx wreg/regen/exen", {dout[0].wreg, dout[0].regen, dout[0].exen}, {5'd30, 1'b1, 1'b1});
    send(0, it(5'd5, 5'd2, 5'd1, 17'h1FFFF));
    chk("imm neg", dout[0].imm, 32'hFFFF_FFFF);
    send(0, it(5'd5, 5'd2, 5'd1, 17'h0FFFF));
    chk("imm pos", dout[0].imm, 32'h0000_FFFF);
    // back-pressure from execute
    send(0, rt3(5'd0, 5'd9, 5'd10, 5'd11));
    pc_hold = pc[0] - 12'd1;
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    insn[0] = rt3(5'd0, 5'd12, 5'd13, 5'd14);
    repeat (4) begin
      @(negedge clk);
      chk("stall in_ready", irdy[0], 1'b0);
      chk("stall pc held", dout[0].pc, pc_hold);
      tick;
    end
    ordy[0] = 1'b1;
    send(0, rt3(5'd0, 5'd12, 5'd13, 5'd14));
    chk("resume pc", dout[0].pc, pc_hold + 12'd1);
    // flush against a full D/X and an offered instruction
    send(0, rt3(5'd0, 5'd1, 5'd2, 5'd3));
    fl[0] = 1'b1;
    iv[0] = 1'b1;
    insn[0] = rt3(5'd0, 5'd4, 5'd5, 5'd6);
    tick;
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    chk("flush out_valid", ov[0], 1'b0);
    tick;
    chk("flush dropped", ov[0], 1'b0);
    // reset mid-stream
    send(0, it(5'd8, 5'd7, 5'd1, 17'h123));
    rst[0] = 1'b1;
    tick;
    rst[0] = 1'b0;
    chk("midreset out_valid", ov[0], 1'b0);
    chk("midreset outputs", dout[0], '0);
    // illegal opcode passes with every enable clear
    send(0, {5'd9, 27'h5A5_A5A5});
    chk("illegal flag", {ov[0], dout[0].illegal}, 2'b11);
    chk("illegal enables", {dout[0].regen, dout[0].mem_re, dout[0].mem_we, dout[0].br_ne, dout[0].br_lt,
                            dout[0].bex, dout[0].jump, dout[0].jr, dout[0].exen}, 9'd0);
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
